// File: rtl/punc_control.sv
// punc_control: multi-cycle fetch/decode/execute sequencer for the PUnC LC3 datapath.
// Outputs are decoded combinationally from the current state, the instruction word
// and the n/z/p flags; only the state is registered.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ir              instruction word (stable from DECODE until the next FETCH)
//   n, z, p         datapath condition codes
//   pc_clr/inc/ld   PC clear, increment, load from ALU result
//   ir_ld           load IR from memory read port 0
//   addr_mem_sel    memory address: 00 PC, 01 ALU result, 10 store register
//   w_en_mem        memory write (data from RF read port 1)
//   w_rf_sel        RF write data: 00 PC, 01 memory data, 10 ALU result
//   w_en_rf         RF write enable
//   r_addr_0_rf, r_addr_1_rf, w_addr_rf  RF addresses
//   sext_data       sign-extended immediate
//   a_sel, b_sel    ALU operand selects
//   alu_sel         00 ADD, 01 AND, 10 PASS_A, 11 NOT
//   nzp_sel, nzp_ld flag source select and flag load
//   store_ld        capture memory read data into the store register
//   halted          high while in HALT
//
// Build option: define PUNC_ILLEGAL_HALT_EN to send opcodes 1000 and 1101 to HALT;
// otherwise they execute as no-ops.
module punc_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   output logic        pc_clr,
   output logic        pc_inc,
   output logic        pc_ld,
   output logic        ir_ld,
   output logic [1:0]  addr_mem_sel,
   output logic        w_en_mem,
   output logic [1:0]  w_rf_sel,
   output logic        w_en_rf,
   output logic [2:0]  r_addr_0_rf,
   output logic [2:0]  r_addr_1_rf,
   output logic [2:0]  w_addr_rf,
   output logic [15:0] sext_data,
   output logic        a_sel,
   output logic        b_sel,
   output logic [1:0]  alu_sel,
   output logic        nzp_sel,
   output logic        nzp_ld,
   output logic        store_ld,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_SETCC, S_HALT
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] MEM_PC    = 2'b00;
   localparam logic [1:0] MEM_ALU   = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   localparam logic [1:0] RF_PC  = 2'b00;
   localparam logic [1:0] RF_MEM = 2'b01;
   localparam logic [1:0] RF_ALU = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_AND  = 2'b01;
   localparam logic [1:0] ALU_PASS = 2'b10;
   localparam logic [1:0] ALU_NOT  = 2'b11;

   state_t state, state_nx;

   // Instruction fields and immediates
   logic [3:0]  opcode;
   logic [2:0]  dr, sr1, sr2;
   logic [15:0] sext5, sext6, sext9, sext11;
   logic        br_taken;

   assign opcode   = ir[15:12];
   assign dr       = ir[11:9];
   assign sr1      = ir[8:6];
   assign sr2      = ir[2:0];
   assign sext5    = {{11{ir[4]}},  ir[4:0]};
   assign sext6    = {{10{ir[5]}},  ir[5:0]};
   assign sext9    = {{7{ir[8]}},   ir[8:0]};
   assign sext11   = {{5{ir[10]}},  ir[10:0]};
   assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_INIT;
      else     state <= state_nx;
   end

   // Next-state and output decode
   always_comb begin
      state_nx     = state;
      pc_clr       = 1'b0;
      pc_inc       = 1'b0;
      pc_ld        = 1'b0;
      ir_ld        = 1'b0;
      addr_mem_sel = MEM_PC;
      w_en_mem     = 1'b0;
      w_rf_sel     = RF_PC;
      w_en_rf      = 1'b0;
      r_addr_0_rf  = 3'd0;
      r_addr_1_rf  = 3'd0;
      w_addr_rf    = 3'd0;
      sext_data    = 16'd0;
      a_sel        = 1'b0;
      b_sel        = 1'b0;
      alu_sel      = ALU_ADD;
      nzp_sel      = 1'b0;
      nzp_ld       = 1'b0;
      store_ld     = 1'b0;
      halted       = 1'b0;

      case (state)
         S_INIT: begin
            pc_clr   = 1'b1;
            state_nx = S_FETCH;
         end

         S_FETCH: begin
            ir_ld        = 1'b1;
            addr_mem_sel = MEM_PC;
            state_nx     = S_DECODE;
         end

         S_DECODE: begin
            pc_inc   = 1'b1;
            state_nx = S_EXEC;
         end

         S_EXEC: begin
            state_nx = S_FETCH;
            case (opcode)
               OP_ADD, OP_AND, OP_NOT: begin
                  a_sel       = 1'b1;
                  r_addr_0_rf = sr1;
                  b_sel       = ir[5];
                  if (ir[5]) sext_data   = sext5;
                  else       r_addr_1_rf = sr2;
                  if (opcode == OP_AND)      alu_sel = ALU_AND;
                  else if (opcode == OP_NOT) alu_sel = ALU_NOT;
                  else                       alu_sel = ALU_ADD;
                  w_rf_sel  = RF_ALU;
                  w_en_rf   = 1'b1;
                  w_addr_rf = dr;
                  nzp_ld    = 1'b1;
               end

               OP_BR: begin
                  b_sel     = 1'b1;
                  sext_data = sext9;
                  pc_ld     = br_taken;
               end

               OP_JMP: begin
                  a_sel       = 1'b1;
                  r_addr_0_rf = sr1;
                  alu_sel     = ALU_PASS;
                  pc_ld       = 1'b1;
               end

               // Link write samples the old PC, so JSRR R7 still jumps to the old R7
               OP_JSR: begin
                  w_en_rf   = 1'b1;
                  w_addr_rf = 3'd7;
                  w_rf_sel  = RF_PC;
                  pc_ld     = 1'b1;
                  if (ir[11]) begin
                     b_sel     = 1'b1;
                     sext_data = sext11;
                  end else begin
                     a_sel       = 1'b1;
                     r_addr_0_rf = sr1;
                     alu_sel     = ALU_PASS;
                  end
               end

               OP_LD, OP_LDR: begin
                  addr_mem_sel = MEM_ALU;
                  b_sel        = 1'b1;
                  if (opcode == OP_LDR) begin
                     a_sel       = 1'b1;
                     r_addr_0_rf = sr1;
                     sext_data   = sext6;
                  end else begin
                     sext_data   = sext9;
                  end
                  w_rf_sel  = RF_MEM;
                  w_en_rf   = 1'b1;
                  w_addr_rf = dr;
                  state_nx  = S_SETCC;
               end

               OP_LEA: begin
                  b_sel     = 1'b1;
                  sext_data = sext9;
                  w_rf_sel  = RF_ALU;
                  w_en_rf   = 1'b1;
                  w_addr_rf = dr;
               end

               OP_ST, OP_STR: begin
                  addr_mem_sel = MEM_ALU;
                  b_sel        = 1'b1;
                  if (opcode == OP_STR) begin
                     a_sel       = 1'b1;
                     r_addr_0_rf = sr1;
                     sext_data   = sext6;
                  end else begin
                     sext_data   = sext9;
                  end
                  r_addr_1_rf = dr;
                  w_en_mem    = 1'b1;
               end

               // Fetch the pointer; the indirect access happens in EXEC2
               OP_LDI, OP_STI: begin
                  addr_mem_sel = MEM_ALU;
                  b_sel        = 1'b1;
                  sext_data    = sext9;
                  store_ld     = 1'b1;
                  state_nx     = S_EXEC2;
               end

               OP_TRAP: state_nx = S_HALT;

               // Reserved opcodes 1000 and 1101
               default: begin
`ifdef PUNC_ILLEGAL_HALT_EN
                  state_nx = S_HALT;
`else
                  state_nx = S_FETCH;
`endif
               end
            endcase
         end

         S_EXEC2: begin
            addr_mem_sel = MEM_STORE;
            if (opcode == OP_LDI) begin
               w_rf_sel  = RF_MEM;
               w_en_rf   = 1'b1;
               w_addr_rf = dr;
               state_nx  = S_SETCC;
            end else begin
               r_addr_1_rf = dr;
               w_en_mem    = 1'b1;
               state_nx    = S_FETCH;
            end
         end

         // Flags for loads come from the freshly written destination register
         S_SETCC: begin
            r_addr_0_rf = dr;
            nzp_sel     = 1'b1;
            nzp_ld      = 1'b1;
            state_nx    = S_FETCH;
         end

         S_HALT: begin
            halted   = 1'b1;
            state_nx = S_HALT;
         end

         default: state_nx = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control: directed, table-driven check of punc_control, plus hand-written
// sequences for asynchronous reset out of HALT and out of a pending EXEC2 store.
module tb_punc_control;

   typedef struct packed {
      logic        pc_clr;
      logic        pc_inc;
      logic        pc_ld;
      logic        ir_ld;
      logic [1:0]  addr_mem_sel;
      logic        w_en_mem;
      logic [1:0]  w_rf_sel;
      logic        w_en_rf;
      logic [2:0]  r0;
      logic [2:0]  r1;
      logic [2:0]  wa;
      logic [15:0] sext;
      logic        a_sel;
      logic        b_sel;
      logic [1:0]  alu_sel;
      logic        nzp_sel;
      logic        nzp_ld;
      logic        store_ld;
      logic        halted;
   } out_t;

   typedef struct {
      string       name;
      logic        rst;
      logic [15:0] ir;
      logic [2:0]  nzp;
      out_t        exp;
      out_t        care;
   } vec_t;

   logic        clk, rst;
   logic [15:0] ir;
   logic        n, z, p;
   logic        pc_clr, pc_inc, pc_ld, ir_ld;
   logic [1:0]  addr_mem_sel;
   logic        w_en_mem;
   logic [1:0]  w_rf_sel;
   logic        w_en_rf;
   logic [2:0]  r_addr_0_rf, r_addr_1_rf, w_addr_rf;
   logic [15:0] sext_data;
   logic        a_sel, b_sel;
   logic [1:0]  alu_sel;
   logic        nzp_sel, nzp_ld, store_ld, halted;

   out_t act;
   out_t m_all, m_ctl;
   vec_t vq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   punc_control dut (
      .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
      .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_ld(ir_ld),
      .addr_mem_sel(addr_mem_sel), .w_en_mem(w_en_mem), .w_rf_sel(w_rf_sel),
      .w_en_rf(w_en_rf), .r_addr_0_rf(r_addr_0_rf), .r_addr_1_rf(r_addr_1_rf),
      .w_addr_rf(w_addr_rf), .sext_data(sext_data), .a_sel(a_sel), .b_sel(b_sel),
      .alu_sel(alu_sel), .nzp_sel(nzp_sel), .nzp_ld(nzp_ld), .store_ld(store_ld),
      .halted(halted)
   );

   assign act = {pc_clr, pc_inc, pc_ld, ir_ld, addr_mem_sel, w_en_mem, w_rf_sel,
                 w_en_rf, r_addr_0_rf, r_addr_1_rf, w_addr_rf, sext_data, a_sel,
                 b_sel, alu_sel, nzp_sel, nzp_ld, store_ld, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t o_init();
      out_t o = '0; o.pc_clr = 1'b1; return o;
   endfunction
   function automatic out_t o_fetch();
      out_t o = '0; o.ir_ld = 1'b1; return o;
   endfunction
   function automatic out_t o_decode();
      out_t o = '0; o.pc_inc = 1'b1; return o;
   endfunction
   function automatic out_t o_halt();
      out_t o = '0; o.halted = 1'b1; return o;
   endfunction

   function automatic void add(input string nm, input logic r, input logic [15:0] i,
                               input logic [2:0] f, input out_t e, input out_t c);
      vec_t v;
      v.name = nm; v.rst = r; v.ir = i; v.nzp = f; v.exp = e; v.care = c;
      vq.push_back(v);
   endfunction

   function automatic void fd(input string nm, input logic [15:0] i);
      add({nm, "_fetch"},  1'b0, i, 3'b000, o_fetch(),  m_all);
      add({nm, "_decode"}, 1'b0, i, 3'b000, o_decode(), m_all);
   endfunction

   task automatic chk(input string nm, input out_t e, input out_t c);
      n_checks++;
      if ((act & c) !== (e & c)) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (care %h)", nm, act, e, c);
      end
   endtask

   initial begin
      out_t e;
      out_t e_sti2;

      m_all = '1;
      m_ctl = '0;
      m_ctl.pc_clr = 1'b1; m_ctl.pc_inc = 1'b1; m_ctl.pc_ld = 1'b1;
      m_ctl.ir_ld = 1'b1;  m_ctl.w_en_mem = 1'b1; m_ctl.w_en_rf = 1'b1;
      m_ctl.nzp_ld = 1'b1; m_ctl.store_ld = 1'b1; m_ctl.halted = 1'b1;

      // Reset, then ADD R1,R1,#-1
      add("reset", 1'b1, 16'h0000, 3'b000, o_init(), m_all);
      add("init",  1'b0, 16'h127F, 3'b000, o_init(), m_all);
      fd("add", 16'h127F);
      e = '0; e.a_sel = 1; e.r0 = 3'd1; e.b_sel = 1; e.sext = 16'hFFFF;
      e.w_rf_sel = 2'b10; e.w_en_rf = 1; e.wa = 3'd1; e.nzp_ld = 1;
      add("add_exec", 1'b0, 16'h127F, 3'b000, e, m_all);

      // BRz #3 taken (z=1) and not taken (n=1,p=1)
      fd("brz_t", 16'h0403);
      e = '0; e.pc_ld = 1; e.b_sel = 1; e.sext = 16'h0003;
      add("brz_t_exec", 1'b0, 16'h0403, 3'b010, e, m_all);
      fd("brz_n", 16'h0403);
      e = '0;
      add("brz_n_exec", 1'b0, 16'h0403, 3'b101, e, m_ctl);

      // LDI R2,#-2: five cycles
      fd("ldi", 16'hA5FE);
      e = '0; e.store_ld = 1; e.addr_mem_sel = 2'b01; e.b_sel = 1; e.sext = 16'hFFFE;
      add("ldi_exec", 1'b0, 16'hA5FE, 3'b000, e, m_all);
      e = '0; e.addr_mem_sel = 2'b10; e.w_rf_sel = 2'b01; e.w_en_rf = 1; e.wa = 3'd2;
      add("ldi_exec2", 1'b0, 16'hA5FE, 3'b000, e, m_all);
      e = '0; e.r0 = 3'd2; e.nzp_sel = 1; e.nzp_ld = 1;
      add("ldi_setcc", 1'b0, 16'hA5FE, 3'b000, e, m_all);

      // JSRR R7
      fd("jsrr", 16'h41C0);
      e = '0; e.w_en_rf = 1; e.wa = 3'd7; e.w_rf_sel = 2'b00; e.pc_ld = 1;
      e.a_sel = 1; e.r0 = 3'd7; e.alu_sel = 2'b10;
      add("jsrr_exec", 1'b0, 16'h41C0, 3'b000, e, m_all);

      // AND R1,R2,R3 (register form)
      fd("and", 16'h5283);
      e = '0; e.a_sel = 1; e.r0 = 3'd2; e.r1 = 3'd3; e.alu_sel = 2'b01;
      e.w_rf_sel = 2'b10; e.w_en_rf = 1; e.wa = 3'd1; e.nzp_ld = 1;
      add("and_exec", 1'b0, 16'h5283, 3'b000, e, m_all);

      // LEA R2,#-2: no flag update
      fd("lea", 16'hE5FE);
      e = '0; e.b_sel = 1; e.sext = 16'hFFFE; e.w_rf_sel = 2'b10; e.w_en_rf = 1; e.wa = 3'd2;
      add("lea_exec", 1'b0, 16'hE5FE, 3'b000, e, m_all);

      // STI R3,#-3: four cycles
      fd("sti", 16'hB7FD);
      e = '0; e.store_ld = 1; e.addr_mem_sel = 2'b01; e.b_sel = 1; e.sext = 16'hFFFD;
      add("sti_exec", 1'b0, 16'hB7FD, 3'b000, e, m_all);
      e_sti2 = '0; e_sti2.addr_mem_sel = 2'b10; e_sti2.w_en_mem = 1; e_sti2.r1 = 3'd3;
      add("sti_exec2", 1'b0, 16'hB7FD, 3'b000, e_sti2, m_all);

      // LDR R5,R1,#-1: four cycles
      fd("ldr", 16'h6A7F);
      e = '0; e.addr_mem_sel = 2'b01; e.a_sel = 1; e.r0 = 3'd1; e.b_sel = 1;
      e.sext = 16'hFFFF; e.w_rf_sel = 2'b01; e.w_en_rf = 1; e.wa = 3'd5;
      add("ldr_exec", 1'b0, 16'h6A7F, 3'b000, e, m_all);
      e = '0; e.r0 = 3'd5; e.nzp_sel = 1; e.nzp_ld = 1;
      add("ldr_setcc", 1'b0, 16'h6A7F, 3'b000, e, m_all);

      // Reserved opcode 1000
      fd("rsv", 16'h8000);
      add("rsv_exec", 1'b0, 16'h8000, 3'b000, '0, m_all);
`ifdef PUNC_ILLEGAL_HALT_EN
      add("rsv_halt0", 1'b0, 16'h8000, 3'b000, o_halt(), m_all);
      add("rsv_halt1", 1'b0, 16'h8000, 3'b000, o_halt(), m_all);
`else
      // TRAP x25 then absorbing HALT
      fd("trap", 16'hF025);
      add("trap_exec",  1'b0, 16'hF025, 3'b000, '0, m_all);
      add("trap_halt0", 1'b0, 16'hF025, 3'b000, o_halt(), m_all);
      add("trap_halt1", 1'b0, 16'hF025, 3'b000, o_halt(), m_all);
      add("trap_halt2", 1'b0, 16'h1234, 3'b111, o_halt(), m_all);
`endif

      rst = 1'b1; ir = 16'h0000; n = 1'b0; z = 1'b0; p = 1'b0;

      // One vector per clock: drive just after the rising edge, check at the falling edge
      foreach (vq[i]) begin
         @(posedge clk);
         #1;
         rst = vq[i].rst; ir = vq[i].ir;
         n = vq[i].nzp[2]; z = vq[i].nzp[1]; p = vq[i].nzp[0];
         @(negedge clk);
         chk(vq[i].name, vq[i].exp, vq[i].care);
      end

      // Asynchronous reset mid-cycle while halted
      #2 rst = 1'b1;
      #1 chk("rst_in_halt", o_init(), m_all);
      @(posedge clk); #1 rst = 1'b0; ir = 16'hB7FD; n = 1'b0; z = 1'b0; p = 1'b0;
      @(negedge clk); chk("rst_halt_init", o_init(), m_all);
      @(negedge clk); chk("rst_halt_fetch", o_fetch(), m_all);

      // Asynchronous reset during STI's EXEC2 must abort the store
      @(negedge clk); chk("abort_decode", o_decode(), m_all);
      @(negedge clk);
      @(negedge clk); chk("abort_exec2", e_sti2, m_all);
      #2 rst = 1'b1;
      #1 chk("abort_store", o_init(), m_all);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("abort_init", o_init(), m_all);
      @(negedge clk); chk("abort_fetch", o_fetch(), m_all);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor. It sequences the multi-cycle fetch/decode/execute loop and drives every select, load and write-enable of the PUnC datapath from the instruction word and the datapath's n/z/p flags. It is a Moore/Mealy FSM whose outputs are decoded combinationally from the current state and the instruction register. It is the only block upstream of the datapath's control inputs.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir  in  16  current instruction from datapath; must be stable from the first DECODE cycle until the next FETCH.
- n, z, p  in  1 each  condition codes from datapath.
- pc_clr, pc_inc, pc_ld  out  1 each  PC controls; pc_ld always loads the ALU result.
- ir_ld  out  1  load IR from memory read port 0.
- addr_mem_sel  out  2  memory address: 00 PC, 01 ALU result, 10 store register.
- w_en_mem  out  1  memory write; data is RF read port 1.
- w_rf_sel  out  2  RF write data: 00 PC, 01 memory data, 10 ALU result.
- w_en_rf  out  1  RF write enable.
- r_addr_0_rf, r_addr_1_rf, w_addr_rf  out  3 each  RF addresses.
- sext_data  out  16  sign-extended immediate.
- a_sel  out  1  ALU A: 0 PC, 1 RF port 0.
- b_sel  out  1  ALU B: 0 RF port 1, 1 sext_data.
- alu_sel  out  2  00 ADD, 01 AND, 10 PASS_A, 11 NOT.
- nzp_sel  out  1  flag source: 0 ALU result, 1 RF port 0.
- nzp_ld  out  1  update n/z/p.
- store_ld  out  1  capture memory read data into the datapath store register.
- halted  out  1  high in HALT.

## Operation
- Outputs default to 0 in every state unless listed.
- States: INIT, FETCH, DECODE, EXEC, EXEC2, SETCC, HALT.
- INIT: assert pc_clr, then go to FETCH.
- FETCH: assert ir_ld with addr_mem_sel=00, then go to DECODE.
- DECODE: assert pc_inc, then go to EXEC.
- EXEC, keyed on opcode ir[15:12]:
  - ADD 0001 / AND 0101: a_sel=1, r0=SR1, then b_sel=ir[5] with sext_data=sext(ir[4:0]) or r1=SR2. Write DR with w_rf_sel=10 and assert nzp_ld. Go to FETCH.
  - NOT 1001: alu_sel=11. Otherwise as ADD.
  - BR 0000: when (ir[11]&n)|(ir[10]&z)|(ir[9]&p), assert pc_ld with PC+sext(ir[8:0]). Go to FETCH.
  - JMP 1100: pc_ld with PASS_A of RF[ir[8:6]].
  - JSR 0100: write R7<-PC (w_rf_sel=00). In the same cycle, pc_ld with PC+sext(ir[10:0]) if ir[11], else PASS_A RF[ir[8:6]]. JSRR R7 jumps to the old R7.
  - LD 0010 / LDR 0110: addr_mem_sel=01. Address is PC+sext9 or BaseR+sext6. Write DR with w_rf_sel=01. Go to SETCC.
  - LEA 1110: write DR with PC+sext9. No flag update.
  - ST 0011 / STR 0111: addr_mem_sel=01, r1=SR, w_en_mem. Go to FETCH.
  - LDI 1010 / STI 1011: store_ld at address PC+sext9, then go to EXEC2.
  - TRAP 1111: go to HALT for any vector.
  - 1000, 1101: no operation. Go to FETCH.
- EXEC2: addr_mem_sel=10.
  - LDI: write DR from memory, then go to SETCC.
  - STI: w_en_mem with r1=SR, then go to FETCH.
- SETCC: r0=DR, nzp_sel=1, nzp_ld. Go to FETCH.
- HALT: absorbing state. Only rst leaves it.
- All sign extension is two's complement to 16 bits. PC arithmetic wraps modulo 2^16.

## Timing
- Reset: state=INIT and all outputs 0, except that pc_clr is asserted combinationally in INIT. Reset effect is immediate and aborts any instruction, including a pending EXEC2 store.
- Cycles per instruction:
  - ALU ops, BR, JMP, JSR, LEA, ST, STR: 3 (FETCH, DECODE, EXEC).
  - LD, LDR, STI: 4.
  - LDI: 5.
- First FETCH occurs in the second cycle after rst deasserts.
- BR samples n/z/p in EXEC. A flag update in the previous instruction's last cycle is visible.
- halted rises in the cycle after TRAP's EXEC.

## Configuration
- PUNC_ILLEGAL_HALT_EN:
  - Defined: opcodes 1000 and 1101 go to HALT.
  - Undefined: they execute as 3-cycle no-ops.

## Test plan
- Reset then `ADD R1,R1,#-1` (0x127F): pc_clr in cycle 1, ir_ld in cycle 2. In EXEC: b_sel=1, sext_data=0xFFFF, w_addr_rf=1, w_en_rf=1, nzp_ld=1.
- `BRz #3` (0x0403) with z=1, then with z=0: pc_ld=1, a_sel=0, sext_data=0x0003 in the first case; pc_ld=0 in the second.
- `LDI R2,#-2` (0xA5FE): EXEC store_ld=1 and sext_data=0xFFFE. EXEC2 addr_mem_sel=10 and w_addr_rf=2. SETCC r_addr_0_rf=2 and nzp_sel=1. Total 5 cycles.
- `JSRR R7` (0x41C0): in a single cycle, w_en_rf=1, w_addr_rf=7, w_rf_sel=00, pc_ld=1, r_addr_0_rf=7, alu_sel=10.
- `TRAP x25` (0xF025): halted=1 thereafter, no further ir_ld. Asserting rst mid-HALT returns the block to INIT immediately.
- Opcode 0x8000: 3-cycle no-op without PUNC_ILLEGAL_HALT_EN; halted=1 with it defined.
